// File: rtl/left_normalizer.sv
// Post-add normalize and round stage of the FP adder.
// It cancels leading zeros one bit per cycle, or takes a single right shift on
// carry-out, and then rounds to nearest-even.
module left_normalizer #(
    parameter int n   = 23,
    parameter int exp = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [n+1:0]   in_mant,
    input  logic [exp-1:0] in_exp,
    input  logic           in_sign,
    input  logic           in_r,
    input  logic           in_s,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [n-1:0]   out_mant,
    output logic [exp-1:0] out_exp,
    output logic           out_sign,
    output logic           out_zero,
    output logic           out_overflow,
    output logic [2:0]     fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and payload holds while valid && !ready.
    typedef enum logic [2:0] {IDLE, CHECK, SHIFT, ROUND, DONE} state_t;

    localparam logic [exp:0] E_ONE = {{exp{1'b0}}, 1'b1};
    localparam logic [exp:0] E_MAX = {1'b0, {exp{1'b1}}};

    state_t       state;
    logic [n+1:0] m;
    logic         r;
    logic         s;
    logic [exp:0] e;

    logic         inc;
    logic [n+1:0] sum;
    logic [n+1:0] m_rnd;
    logic [exp:0] e_rnd;
    logic         ovf;

    // Round-to-nearest-even, then fix up a round carry or a subnormal
    // that has been promoted to a normal number.
    always_comb begin
        inc   = r & (s | m[0]);
        sum   = m + {{(n+1){1'b0}}, inc};
        m_rnd = sum;
        e_rnd = e;
        if (sum[n+1]) begin
            m_rnd = sum >> 1;
            e_rnd = e + E_ONE;
        end else if (e == '0 && sum[n]) begin
            e_rnd = E_ONE;
        end
        ovf = (e_rnd >= E_MAX);
    end

    assign in_ready  = (state == IDLE) && !rst;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            m            <= '0;
            r            <= 1'b0;
            s            <= 1'b0;
            e            <= '0;
            out_valid    <= 1'b0;
            out_mant     <= '0;
            out_exp      <= '0;
            out_sign     <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m        <= in_mant;
                        r        <= in_r;
                        s        <= in_s;
                        e        <= (in_exp == '0) ? E_ONE : {1'b0, in_exp};
                        out_sign <= in_sign;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (m == '0 && !r) begin
                        e            <= '0;
                        s            <= 1'b0;
                        out_mant     <= '0;
                        out_exp      <= '0;
                        out_zero     <= 1'b1;
                        out_overflow <= 1'b0;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end else if (m[n+1]) begin
                        m     <= m >> 1;
                        r     <= m[0];
                        s     <= s | r;
                        e     <= e + E_ONE;
                        state <= ROUND;
                    end else if (m[n]) begin
                        state <= ROUND;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Exponent floor reached: stop here and leave it subnormal.
                    if (e == E_ONE) begin
                        e     <= '0;
                        state <= ROUND;
                    end else begin
                        m <= {m[n:0], r};
                        r <= 1'b0;
                        e <= e - E_ONE;
                        if (m[n-1]) state <= ROUND;
                    end
                end
                ROUND: begin
                    m         <= m_rnd;
                    e         <= e_rnd;
                    out_valid <= 1'b1;
                    out_zero  <= 1'b0;
                    if (ovf) begin
                        out_exp      <= '1;
                        out_mant     <= '0;
                        out_overflow <= 1'b1;
                    end else begin
                        out_exp      <= e_rnd[exp-1:0];
                        out_mant     <= m_rnd[n-1:0];
                        out_overflow <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_left_normalizer.sv
// Scoreboard bench for left_normalizer: directed cases with hand-derived results,
// then randomized traffic checked against an arithmetic reference model.
module tb_left_normalizer;

    localparam int N  = 23;
    localparam int EW = 8;
    localparam int W  = N + EW + 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N+1:0]  in_mant;
    logic [EW-1:0] in_exp;
    logic          in_sign;
    logic          in_r;
    logic          in_s;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_mant;
    logic [EW-1:0] out_exp;
    logic          out_sign;
    logic          out_zero;
    logic          out_overflow;
    logic [2:0]    fsm_state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic bp_hold = 1'b0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    left_normalizer #(.n(N), .exp(EW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign), .in_r(in_r), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
        .out_sign(out_sign), .out_zero(out_zero), .out_overflow(out_overflow),
        .fsm_state(fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream readiness: random, unless a backpressure window is forced
    initial out_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        out_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [N-1:0] mant, input logic [EW-1:0] e,
                                          input logic sg, input logic z, input logic o,
                                          input logic [7:0] lat);
        return {mant, e, sg, z, o, lat};
    endfunction

    // Reference: count leading zeros of {m,r}, clamp the shift at the exponent floor, then round.
    function automatic logic [W-1:0] model(input logic [N+1:0] mant, input logic [EW-1:0] ie,
                                           input logic sg, input logic r, input logic s);
        longint m, e, x, k, shifts, lat, inc;
        logic rr, ss;
        int p;
        if (mant == '0 && !r) return pack('0, '0, sg, 1'b1, 1'b0, 8'd2);
        m = longint'(mant);
        rr = r;
        ss = s;
        e = (ie == '0) ? 1 : longint'(ie);
        lat = 3;
        if (m >= (64'd1 << (N + 1))) begin
            ss = ss | rr;
            rr = m[0];
            m = m >> 1;
            e = e + 1;
        end else if (m < (64'd1 << N)) begin
            x = (m << 1) | longint'(rr);
            p = 0;
            for (int i = 0; i <= N + 1; i++) if (x[i]) p = i;
            shifts = longint'(N + 1 - p);
            if (shifts <= e - 1) begin
                k = shifts;
                e = e - k;
            end else begin
                k = e - 1;
                e = 0;
                lat = lat + 1;
            end
            x = x << k;
            m = x >> 1;
            rr = x[0];
            lat = lat + k;
        end
        inc = longint'(rr & (ss | m[0]));
        m = m + inc;
        if (m >= (64'd1 << (N + 1))) begin
            m = m >> 1;
            e = e + 1;
        end else if (e == 0 && m >= (64'd1 << N)) begin
            e = 1;
        end
        if (e >= (64'd1 << EW) - 1) return pack('0, {EW{1'b1}}, sg, 1'b0, 1'b1, lat[7:0]);
        return pack(m[N-1:0], e[EW-1:0], sg, 1'b0, 1'b0, lat[7:0]);
    endfunction

    // Driver: called in the posedge+1 phase; waits for in_ready, then issues one transfer
    task automatic send(input logic [N+1:0] mant, input logic [EW-1:0] e, input logic sg,
                        input logic r, input logic s, input logic push, input logic [W-1:0] expv);
        int waited = 0;
        while (!in_ready && waited < 300) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 want 1 after %0d cycles", waited);
            return;
        end
        in_mant  = mant;
        in_exp   = e;
        in_sign  = sg;
        in_r     = r;
        in_s     = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) begin
            exp_q.push_back(expv);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic send_model(input logic [N+1:0] mant, input logic [EW-1:0] e, input logic sg,
                              input logic r, input logic s);
        send(mant, e, sg, r, s, 1'b1, model(mant, e, sg, r, s));
    endtask

    // Monitor / scoreboard: compare on first sight of out_valid, then check hold while stalled
    logic         checked = 1'b0;
    logic         orphan  = 1'b0;
    logic [W-1:0] cur;
    int           acc;
    always @(negedge clk) begin
        if (rst) begin
            checked = 1'b0;
        end else if (out_valid) begin
            if (!checked) begin
                checked = 1'b1;
                if (exp_q.size() == 0) begin
                    orphan = 1'b1;
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got out_valid=1 want no output (cycle %0d)", cyc);
                end else begin
                    orphan = 1'b0;
                    cur = exp_q.pop_front();
                    acc = acc_q.pop_front();
                    chk("out_mant", 64'(out_mant), 64'(cur[W-1 -: N]));
                    chk("out_exp", 64'(out_exp), 64'(cur[W-1-N -: EW]));
                    chk("out_sign", 64'(out_sign), 64'(cur[10]));
                    chk("out_zero", 64'(out_zero), 64'(cur[9]));
                    chk("out_overflow", 64'(out_overflow), 64'(cur[8]));
                    chk("latency", 64'(cyc - acc + 1), 64'(cur[7:0]));
                    chk("in_ready_busy", 64'(in_ready), 64'd0);
                end
            end else if (!orphan) begin
                chk("hold_mant", 64'(out_mant), 64'(cur[W-1 -: N]));
                chk("hold_exp", 64'(out_exp), 64'(cur[W-1-N -: EW]));
                chk("hold_flags", 64'({out_sign, out_zero, out_overflow}), 64'(cur[10:8]));
                chk("hold_in_ready", 64'(in_ready), 64'd0);
            end
            if (out_ready) checked = 1'b0;
        end
    end

    initial begin : stim
        logic [31:0]   w;
        logic [N+1:0]  mm;
        logic [EW-1:0] ev;
        int sel;
        int waited;

        rst = 1'b1;
        in_valid = 1'b0;
        in_mant = '0;
        in_exp = '0;
        in_sign = 1'b0;
        in_r = 1'b0;
        in_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_mant", 64'(out_mant), 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_out_flags", 64'({out_sign, out_zero, out_overflow}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed cases with hand-derived results
        send(26'h0800000, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, pack(23'h000000, 8'h7F, 1'b0, 1'b0, 1'b0, 8'd3));
        send(26'h1000001, 8'h80, 1'b1, 1'b1, 1'b0, 1'b1, pack(23'h000001, 8'h81, 1'b1, 1'b0, 1'b0, 8'd3));
        send(26'h0000100, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, pack(23'h000000, 8'h71, 1'b0, 1'b0, 1'b0, 8'd18));
        send(26'h0000000, 8'h40, 1'b1, 1'b0, 1'b1, 1'b1, pack(23'h000000, 8'h00, 1'b1, 1'b1, 1'b0, 8'd2));
        send(26'h1FFFFFF, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1, pack(23'h000000, 8'hFF, 1'b0, 1'b0, 1'b1, 8'd3));
        send(26'h0800000, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, pack(23'h000000, 8'h7F, 1'b0, 1'b0, 1'b0, 8'd3));
        send(26'h0800001, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, pack(23'h000002, 8'h7F, 1'b0, 1'b0, 1'b0, 8'd3));
        send(26'h0000004, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, pack(23'h000010, 8'h00, 1'b0, 1'b0, 1'b0, 8'd6));
        send(26'h0800000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, pack(23'h000000, 8'h01, 1'b0, 1'b0, 1'b0, 8'd3));
        send(26'h07FFFFF, 8'h01, 1'b1, 1'b1, 1'b1, 1'b1, pack(23'h000000, 8'h01, 1'b1, 1'b0, 1'b0, 8'd4));

        // Backpressure: hold out_ready low for 5 cycles while a result is waiting
        waited = 0;
        while ((exp_q.size() != 0 || out_valid) && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        bp_hold = 1'b1;
        send(26'h0C00003, 8'h20, 1'b1, 1'b1, 1'b1, 1'b1, pack(23'h400004, 8'h20, 1'b1, 1'b0, 1'b0, 8'd3));
        waited = 0;
        while (!out_valid && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("bp_still_valid", 64'(out_valid), 64'd1);
        bp_hold = 1'b0;

        // Reset pulse in the middle of a cancellation: the transaction must vanish
        send(26'h0000100, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        chk("in_shift_state", 64'(fsm_state), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pulse_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("after_pulse_in_ready", 64'(in_ready), 64'd1);
        chk("after_pulse_out_valid", 64'(out_valid), 64'd0);
        repeat (25) @(posedge clk);
        #1;

        // Randomized traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            w  = $urandom;
            mm = w[N+1:0];
            mm = mm >> $urandom_range(0, N + 2);
            sel = $urandom_range(0, 3);
            w = $urandom;
            case (sel)
                0: ev = 8'($urandom_range(1, 6));
                1: ev = 8'($urandom_range(250, 254));
                2: ev = 8'h00;
                default: ev = w[7:0];
            endcase
            w = $urandom;
            send_model(mm, ev, w[0], w[1], w[2]);
        end

        waited = 0;
        while ((exp_q.size() != 0 || out_valid) && waited < 1000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
